spi_slave_resp: RTL and testbench

SPI_SLAVE_RESP -- requirements
Module: spi_slave_resp

---
 rtl/spi_slave_resp.sv | 191 +++++++++++++++++++
 tb/tb_spi_slave_resp.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_resp.sv
// SPI slave responder: synchronized SCLK/SS/MOSI, one TX holding register.
// Optional macro SPI_SLAVE_RESP_LSB_FIRST_EN selects LSB-first bit order.
module spi_slave_resp #(
   parameter int WIDTH = 8,
   parameter int CPOL  = 0,
   parameter int CPHA  = 0
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic             sclk_i,
   input  logic             ss_n_i,
   input  logic             mosi_i,
   output logic             miso_o,
   output logic             miso_oe_o,
   input  logic [WIDTH-1:0] tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic [WIDTH-1:0] rx_data_o,
   output logic             rx_valid_o,
   output logic             tx_undr_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic IDLE_LVL = (CPOL != 0);
   localparam logic PHA1 = (CPHA != 0);
`ifdef SPI_SLAVE_RESP_LSB_FIRST_EN
   localparam int TOP = 0;
`else
   localparam int TOP = WIDTH - 1;
`endif

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state_q, state_d;

   logic sclk_s1, sclk_s2, sclk_d;
   logic ss_s1, ss_s2, ss_d;
   logic mosi_s1, mosi_s2;
   logic live_q, armed_q;

   logic [WIDTH-1:0] hold_q;
   logic             full_q;
   logic [WIDTH-1:0] tx_sh;
   logic [WIDTH-1:0] rx_sh;
   logic [WIDTH-1:0] rx_next;
   logic [WIDTH-1:0] load_w;
   logic [CW-1:0]    cnt_q;

   logic sclk_rise, sclk_fall, lead, trail;
   logic ss_fall, ss_rise;
   logic samp_e, out_e;
   logic start, abort, run;
   logic do_samp, do_out, last, wstart, hs;

   function automatic logic [WIDTH-1:0] shift_tx(
      input logic [WIDTH-1:0] v
   );
`ifdef SPI_SLAVE_RESP_LSB_FIRST_EN
      return {1'b1, v[WIDTH-1:1]};
`else
      return {v[WIDTH-2:0], 1'b1};
`endif
   endfunction

   assign sclk_rise = sclk_s2 & ~sclk_d;
   assign sclk_fall = ~sclk_s2 & sclk_d;
   assign lead      = IDLE_LVL ? sclk_fall : sclk_rise;
   assign trail     = IDLE_LVL ? sclk_rise : sclk_fall;
   assign ss_fall   = ~ss_s2 & ss_d;
   assign ss_rise   = ss_s2 & ~ss_d;
   assign samp_e    = PHA1 ? trail : lead;
   assign out_e     = PHA1 ? lead : trail;

   assign hs         = tx_valid_i & tx_ready_o;
   assign tx_ready_o = ~full_q;
   assign miso_oe_o  = (state_q == ACTIVE);
   assign load_w     = full_q ? hold_q : '1;

   // Input synchronizers, edge-detect delay and post-reset arming.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         sclk_s1 <= IDLE_LVL;
         sclk_s2 <= IDLE_LVL;
         sclk_d  <= IDLE_LVL;
         ss_s1   <= 1'b1;
         ss_s2   <= 1'b1;
         ss_d    <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
         live_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sclk_s1 <= sclk_i;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         ss_s1   <= ss_n_i;
         ss_s2   <= ss_s1;
         ss_d    <= ss_s2;
         mosi_s1 <= mosi_i;
         mosi_s2 <= mosi_s1;
         live_q  <= 1'b1;
         if (live_q && ss_s1)
            armed_q <= 1'b1;
      end
   end

   // Next state and per-cycle word control.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      abort   = 1'b0;
      run     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ss_fall && armed_q) begin
               state_d = ACTIVE;
               start   = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d = IDLE;
               abort   = 1'b1;
            end else begin
               run = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      do_samp = run & samp_e;
      last    = do_samp & (cnt_q == LAST);
      wstart  = start | last;
      do_out  = run & out_e & (PHA1 | (cnt_q != '0));
   end

   // Assemble the incoming word in arrival order.
   always_comb begin
`ifdef SPI_SLAVE_RESP_LSB_FIRST_EN
      rx_next = {mosi_s2, rx_sh[WIDTH-1:1]};
`else
      rx_next = {rx_sh[WIDTH-2:0], mosi_s2};
`endif
   end

   // State, holding register, shifters, counter and output pulses.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         full_q     <= 1'b0;
         tx_sh      <= '1;
         rx_sh      <= '0;
         cnt_q      <= '0;
         miso_o     <= 1'b1;
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
         tx_undr_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (hs)
            hold_q <= tx_data_i;
         if (hs)
            full_q <= 1'b1;
         else if (wstart)
            full_q <= 1'b0;
         tx_undr_o <= wstart & ~full_q;
         if (wstart) begin
            if (PHA1) begin
               tx_sh <= load_w;
            end else begin
               miso_o <= load_w[TOP];
               tx_sh  <= shift_tx(load_w);
            end
         end else if (do_out) begin
            miso_o <= tx_sh[TOP];
            tx_sh  <= shift_tx(tx_sh);
         end
         if (abort)
            cnt_q <= '0;
         else if (do_samp)
            cnt_q <= last ? '0 : cnt_q + CW'(1);
         if (do_samp)
            rx_sh <= rx_next;
         rx_valid_o <= last;
         if (last)
            rx_data_o <= rx_next;
      end
   end

endmodule

// File: tb/tb_spi_slave_resp.sv
// Bench for spi_slave_resp: mode 0 and mode 3 instances, master model.
// Honours SPI_SLAVE_RESP_LSB_FIRST_EN for expected bit order.
module tb_spi_slave_resp;

   localparam int H = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic sclk0 = 1'b0, ss0 = 1'b1, mosi0 = 1'b0;
   logic miso0, oe0, rdy0, rxv0, und0;
   logic [7:0] txd0 = '0, rxd0;
   logic txv0 = 1'b0;

   logic sclk3 = 1'b1, ss3 = 1'b1, mosi3 = 1'b0;
   logic miso3, oe3, rdy3, rxv3, und3;
   logic [7:0] txd3 = '0, rxd3;
   logic txv3 = 1'b0;

   int total = 0;
   int bad = 0;
   logic [7:0] rxq0[$];
   logic [7:0] rxq3[$];
   int undc0 = 0;
   int undc3 = 0;

   always #5 clk = ~clk;

   spi_slave_resp #(.WIDTH(8), .CPOL(0), .CPHA(0)) u_m0 (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .sclk_i(sclk0), .ss_n_i(ss0), .mosi_i(mosi0),
      .miso_o(miso0), .miso_oe_o(oe0),
      .tx_data_i(txd0), .tx_valid_i(txv0), .tx_ready_o(rdy0),
      .rx_data_o(rxd0), .rx_valid_o(rxv0), .tx_undr_o(und0)
   );

   spi_slave_resp #(.WIDTH(8), .CPOL(1), .CPHA(1)) u_m3 (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .sclk_i(sclk3), .ss_n_i(ss3), .mosi_i(mosi3),
      .miso_o(miso3), .miso_oe_o(oe3),
      .tx_data_i(txd3), .tx_valid_i(txv3), .tx_ready_o(rdy3),
      .rx_data_o(rxd3), .rx_valid_o(rxv3), .tx_undr_o(und3)
   );

   // Record every received word and underrun pulse.
   always @(posedge clk) begin
      if (rxv0) rxq0.push_back(rxd0);
      if (rxv3) rxq3.push_back(rxd3);
      if (und0) undc0++;
      if (und3) undc3++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int bidx(input int i);
`ifdef SPI_SLAVE_RESP_LSB_FIRST_EN
      return i;
`else
      return 7 - i;
`endif
   endfunction

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_sclk(input bit m, input logic v);
      if (m) sclk3 = v; else sclk0 = v;
   endtask

   task automatic set_ss(input bit m, input logic v);
      if (m) ss3 = v; else ss0 = v;
   endtask

   task automatic set_mosi(input bit m, input logic v);
      if (m) mosi3 = v; else mosi0 = v;
   endtask

   function automatic logic get_miso(input bit m);
      return m ? miso3 : miso0;
   endfunction

   function automatic logic get_rdy(input bit m);
      return m ? rdy3 : rdy0;
   endfunction

   task automatic clr();
      rxq0.delete();
      rxq3.delete();
      undc0 = 0;
      undc3 = 0;
   endtask

   task automatic push(input bit m, input logic [7:0] d);
      int n = 0;
      while (!get_rdy(m) && n < 50) begin
         wclk(1);
         n++;
      end
      total++;
      if (!get_rdy(m)) begin
         bad++;
         $display("FAIL push_wait m=%0d: ready=0 required 1", m);
      end
      if (m) begin txv3 = 1'b1; txd3 = d; end
      else begin txv0 = 1'b1; txd0 = d; end
      wclk(1);
      txv0 = 1'b0;
      txv3 = 1'b0;
      total++;
      if (get_rdy(m) !== 1'b0) begin
         bad++;
         $display("FAIL push_ready_drop m=%0d: got %b required 0",
                  m, get_rdy(m));
      end
   endtask

   task automatic start(input bit m);
      set_ss(m, 1'b0);
      wclk(H);
   endtask

   task automatic stop(input bit m);
      wclk(2);
      set_ss(m, 1'b1);
      wclk(H);
   endtask

   task automatic xfer(input bit m, input logic [7:0] mo,
                       input int nb, output logic [7:0] mi);
      logic idle;
      idle = m;
      mi = '0;
      for (int i = 0; i < nb; i++) begin
         if (!m) begin
            set_mosi(m, mo[bidx(i)]);
            wclk(H);
            set_sclk(m, ~idle);
            mi[bidx(i)] = get_miso(m);
            wclk(H);
            set_sclk(m, idle);
         end else begin
            set_sclk(m, ~idle);
            set_mosi(m, mo[bidx(i)]);
            wclk(H);
            set_sclk(m, idle);
            mi[bidx(i)] = get_miso(m);
            wclk(H);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wclk(4);
      rst_n = 1'b1;
      wclk(2);
      total++;
      if (miso0 !== 1'b1) begin bad++;
         $display("FAIL rst_miso: got %b required 1", miso0); end
      total++;
      if (oe0 !== 1'b0) begin bad++;
         $display("FAIL rst_oe: got %b required 0", oe0); end
      total++;
      if (rdy0 !== 1'b1) begin bad++;
         $display("FAIL rst_ready: got %b required 1", rdy0); end
      total++;
      if (rxd0 !== 8'h00) begin bad++;
         $display("FAIL rst_rxdata: got %h required 00", rxd0); end
      total++;
      if (rxv0 !== 1'b0 || und0 !== 1'b0) begin bad++;
         $display("FAIL rst_pulses: got %b%b required 00", rxv0, und0); end
      total++;
      if (oe3 !== 1'b0 || rdy3 !== 1'b1) begin bad++;
         $display("FAIL rst_m3: oe/rdy got %b%b required 01", oe3, rdy3); end
   endtask

   task automatic test_basic();
      logic [7:0] mi;
      clr();
      push(0, 8'hA5);
      start(0);
      total++;
      if (oe0 !== 1'b1) begin bad++;
         $display("FAIL basic_oe: got %b required 1", oe0); end
      xfer(0, 8'h3C, 8, mi);
      wclk(6);
      total++;
      if (mi !== 8'hA5) begin bad++;
         $display("FAIL basic_miso: got %h required a5", mi); end
      total++;
      if (rxq0.size() != 1) begin bad++;
         $display("FAIL basic_rxcnt: got %0d required 1", rxq0.size());
      end else begin
         total++;
         if (rxq0[0] !== 8'h3C) begin bad++;
            $display("FAIL basic_rx: got %h required 3c", rxq0[0]); end
      end
      stop(0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] mi;
      clr();
      push(0, 8'h11);
      start(0);
      total++;
      if (rdy0 !== 1'b1) begin bad++;
         $display("FAIL b2b_ready1: got %b required 1", rdy0); end
      push(0, 8'h22);
      xfer(0, 8'hF0, 8, mi);
      total++;
      if (mi !== 8'h11) begin bad++;
         $display("FAIL b2b_miso1: got %h required 11", mi); end
      total++;
      if (rdy0 !== 1'b1) begin bad++;
         $display("FAIL b2b_ready2: got %b required 1", rdy0); end
      xfer(0, 8'h0F, 8, mi);
      wclk(6);
      total++;
      if (mi !== 8'h22) begin bad++;
         $display("FAIL b2b_miso2: got %h required 22", mi); end
      total++;
      if (rxq0.size() != 2) begin bad++;
         $display("FAIL b2b_rxcnt: got %0d required 2", rxq0.size());
      end else begin
         total++;
         if (rxq0[0] !== 8'hF0 || rxq0[1] !== 8'h0F) begin bad++;
            $display("FAIL b2b_rx: got %h %h required f0 0f",
                     rxq0[0], rxq0[1]); end
      end
      stop(0);
   endtask

   task automatic test_underrun();
      logic [7:0] mi, mo;
      clr();
      mo = 8'($urandom);
      start(0);
      total++;
      if (undc0 != 1) begin bad++;
         $display("FAIL undr_pulse: got %0d required 1", undc0); end
      xfer(0, mo, 8, mi);
      wclk(6);
      total++;
      if (mi !== 8'hFF) begin bad++;
         $display("FAIL undr_miso: got %h required ff", mi); end
      total++;
      if (rxq0.size() != 1 || rxq0[0] !== mo) begin bad++;
         $display("FAIL undr_rx: cnt %0d required 1 word %h", rxq0.size(), mo);
      end
      stop(0);
   endtask

   task automatic test_abort();
      logic [7:0] mi;
      clr();
      start(0);
      push(0, 8'h3E);
      xfer(0, 8'hFF, 5, mi);
      stop(0);
      total++;
      if (rxq0.size() != 0) begin bad++;
         $display("FAIL abort_rx: got %0d words required 0", rxq0.size()); end
      total++;
      if (oe0 !== 1'b0) begin bad++;
         $display("FAIL abort_oe: got %b required 0", oe0); end
      start(0);
      xfer(0, 8'h81, 8, mi);
      wclk(6);
      total++;
      if (mi !== 8'h3E) begin bad++;
         $display("FAIL abort_hold: got %h required 3e", mi); end
      total++;
      if (rxq0.size() != 1 || rxd0 !== 8'h81) begin bad++;
         $display("FAIL abort_next: cnt %0d data %h required 1 81",
                  rxq0.size(), rxd0); end
      stop(0);
   endtask

   task automatic test_mode3();
      logic [7:0] mi;
      clr();
      push(1, 8'hC3);
      start(1);
      xfer(1, 8'h5A, 8, mi);
      wclk(6);
      total++;
      if (mi !== 8'hC3) begin bad++;
         $display("FAIL m3_miso: got %h required c3", mi); end
      total++;
      if (rxq3.size() != 1 || rxd3 !== 8'h5A) begin bad++;
         $display("FAIL m3_rx: cnt %0d data %h required 1 5a",
                  rxq3.size(), rxd3); end
      stop(1);
   endtask

   task automatic test_reset_mid();
      logic [7:0] mi;
      clr();
      push(0, 8'h55);
      start(0);
      xfer(0, 8'hAA, 3, mi);
      rst_n = 1'b0;
      wclk(3);
      total++;
      if (oe0 !== 1'b0 || rdy0 !== 1'b1 || miso0 !== 1'b1) begin bad++;
         $display("FAIL rmid_out: oe/rdy/miso got %b%b%b required 011",
                  oe0, rdy0, miso0); end
      total++;
      if (rxd0 !== 8'h00 || rxv0 !== 1'b0 || und0 !== 1'b0) begin bad++;
         $display("FAIL rmid_rx: data %h v %b u %b required 00 0 0",
                  rxd0, rxv0, und0); end
      rst_n = 1'b1;
      wclk(4);
      xfer(0, 8'h96, 8, mi);
      wclk(6);
      total++;
      if (rxq0.size() != 0 || oe0 !== 1'b0) begin bad++;
         $display("FAIL rmid_idle: words %0d oe %b required 0 0",
                  rxq0.size(), oe0); end
      stop(0);
      start(0);
      xfer(0, 8'hC7, 8, mi);
      wclk(6);
      total++;
      if (mi !== 8'hFF || rxq0.size() != 1 || rxd0 !== 8'hC7) begin bad++;
         $display("FAIL rmid_fresh: miso %h words %0d rx %h required ff 1 c7",
                  mi, rxq0.size(), rxd0); end
      stop(0);
   endtask

   task automatic test_random();
      logic [7:0] mi, mo, tx, emi;
      logic [7:0] got;
      bit m, ld;
      int eund, gund, gcnt;
      for (int k = 0; k < 10; k++) begin
         m  = k[0];
         ld = 1'($urandom);
         tx = 8'($urandom);
         mo = 8'($urandom);
         clr();
         if (ld) push(m, tx);
         start(m);
         xfer(m, mo, 8, mi);
         wclk(6);
         emi  = ld ? tx : 8'hFF;
         eund = (ld ? 0 : 1) + 1;
         gund = m ? undc3 : undc0;
         gcnt = m ? rxq3.size() : rxq0.size();
         got  = m ? rxd3 : rxd0;
         total++;
         if (mi !== emi) begin bad++;
            $display("FAIL rnd_miso k=%0d: got %h required %h", k, mi, emi); end
         total++;
         if (gcnt != 1 || got !== mo) begin bad++;
            $display("FAIL rnd_rx k=%0d: cnt %0d data %h required 1 %h",
                     k, gcnt, got, mo); end
         total++;
         if (gund != eund) begin bad++;
            $display("FAIL rnd_undr k=%0d: got %0d required %0d",
                     k, gund, eund); end
         stop(m);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_mode3();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
